// File: rtl/tis100_pkg.sv
// Shared constants for the TIS-100 node sequencer: opcodes, next-IP selects, FSM states.
package tis100_pkg;

    localparam int unsigned ACC_W   = 11;
    localparam int unsigned IP_W    = 8;
    localparam int unsigned INSTR_W = 18;
    localparam int unsigned OP_W    = 5;

    localparam logic [OP_W-1:0] OP_NOP    = 5'h00;
    localparam logic [OP_W-1:0] OP_SWP    = 5'h01;
    localparam logic [OP_W-1:0] OP_SAV    = 5'h02;
    localparam logic [OP_W-1:0] OP_NEG    = 5'h03;
    localparam logic [OP_W-1:0] OP_ADD    = 5'h04;
    localparam logic [OP_W-1:0] OP_SUB    = 5'h05;
    localparam logic [OP_W-1:0] OP_MOV    = 5'h06;
    localparam logic [OP_W-1:0] OP_MOV_RD = 5'h08;
    localparam logic [OP_W-1:0] OP_MOV_WR = 5'h09;
    localparam logic [OP_W-1:0] OP_ADD_RD = 5'h0A;
    localparam logic [OP_W-1:0] OP_SUB_RD = 5'h0B;
    localparam logic [OP_W-1:0] OP_JMP    = 5'h10;
    localparam logic [OP_W-1:0] OP_JEZ    = 5'h11;
    localparam logic [OP_W-1:0] OP_JNZ    = 5'h12;
    localparam logic [OP_W-1:0] OP_JGZ    = 5'h13;
    localparam logic [OP_W-1:0] OP_JLZ    = 5'h14;
    localparam logic [OP_W-1:0] OP_JRO    = 5'h15;

    localparam logic [1:0] SEL_INC   = 2'b00;
    localparam logic [1:0] SEL_JADDR = 2'b01;
    localparam logic [1:0] SEL_ABS   = 2'b10;
    localparam logic [1:0] SEL_ZERO  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/jro_clamp.sv
// JRO target: ip + signed acc at 12-bit width, clamped into [0, prog_last].
module jro_clamp
    import tis100_pkg::*;
(
    input  logic [0:IP_W-1]  ip,
    input  logic [0:ACC_W-1] acc,
    input  logic [0:IP_W-1]  prog_last,
    output logic [0:IP_W-1]  target
);

    localparam int unsigned SUM_W = 12;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] last_ext;

    always_comb begin
        sum      = $signed({{(SUM_W-IP_W){1'b0}}, ip}) + $signed({{(SUM_W-ACC_W){acc[0]}}, acc});
        last_ext = $signed({{(SUM_W-IP_W){1'b0}}, prog_last});
        if (sum[SUM_W-1]) begin
            target = '0;
        end else if (sum > last_ext) begin
            target = prog_last;
        end else begin
            target = sum[IP_W-1:0];
        end
    end

endmodule

// File: rtl/tis_node_seq.sv
// TIS-100 node sequencer: decodes the current instruction, picks the next IP and
// runs the port read/write handshakes.
module tis_node_seq
    import tis100_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic [0:INSTR_W-1] instr,
    input  logic [0:IP_W-1]    ip,
    input  logic [0:IP_W-1]    prog_last,
    input  logic [0:ACC_W-1]   acc,
    input  logic               port_rd_valid,
    input  logic               port_wr_ready,
    output logic [0:1]         jmpCond,
    output logic               jmpInstr,
    output logic [0:IP_W-1]    jAddr,
    output logic               exec_en,
    output logic               port_rd_req,
    output logic               port_wr_req,
    output logic               err_illegal
);

    state_t            state, state_nxt;
    logic [OP_W-1:0]   op;
    logic [IP_W-1:0]   tgt;
    logic [IP_W-1:0]   jro_tgt;
    logic [1:0]        seq_sel;
    logic              acc_zero, acc_neg, taken;
    logic              unused_instr;

    assign op           = instr[0:OP_W-1];
    assign tgt          = instr[INSTR_W-IP_W:INSTR_W-1];
    assign unused_instr = ^instr[OP_W:INSTR_W-IP_W-1];
    assign acc_zero     = (acc == '0);
    assign acc_neg      = acc[0];
    assign seq_sel      = (ip == prog_last) ? SEL_ZERO : SEL_INC;

    jro_clamp u_jro_clamp (
        .ip        (ip),
        .acc       (acc),
        .prog_last (prog_last),
        .target    (jro_tgt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Mealy next-IP/retire decode; IP is held unless something retires.
    always_comb begin
        state_nxt   = state;
        jmpCond     = SEL_JADDR;
        jAddr       = ip;
        jmpInstr    = 1'b0;
        exec_en     = 1'b0;
        port_rd_req = 1'b0;
        port_wr_req = 1'b0;
        err_illegal = 1'b0;
        taken       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!run_en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    exec_en = 1'b1;
                    jmpCond = seq_sel;
                    case (op)
                        OP_NOP, OP_SWP, OP_SAV, OP_NEG, OP_ADD, OP_SUB, OP_MOV: begin
                            exec_en = 1'b1;
                        end
                        OP_MOV_RD, OP_ADD_RD, OP_SUB_RD: begin
                            exec_en   = 1'b0;
                            jmpCond   = SEL_JADDR;
                            state_nxt = ST_RD_WAIT;
                        end
                        OP_MOV_WR: begin
                            exec_en   = 1'b0;
                            jmpCond   = SEL_JADDR;
                            state_nxt = ST_WR_WAIT;
                        end
                        OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: begin
                            jmpInstr = 1'b1;
                            case (op)
                                OP_JEZ:  taken = acc_zero;
                                OP_JNZ:  taken = !acc_zero;
                                OP_JGZ:  taken = !acc_neg && !acc_zero;
                                OP_JLZ:  taken = acc_neg;
                                default: taken = 1'b1;
                            endcase
                            if (taken) begin
                                if (tgt > prog_last) begin
                                    jmpCond     = SEL_ZERO;
                                    err_illegal = 1'b1;
                                end else begin
                                    jmpCond = SEL_ABS;
                                end
                            end
                        end
                        OP_JRO: begin
                            jmpInstr = 1'b1;
                            jmpCond  = SEL_JADDR;
                            jAddr    = jro_tgt;
                        end
                        default: begin
                            err_illegal = 1'b1;
                        end
                    endcase
                end
            end
            ST_RD_WAIT: begin
                port_rd_req = 1'b1;
                if (port_rd_valid) begin
                    exec_en   = 1'b1;
                    jmpCond   = seq_sel;
                    state_nxt = ST_RUN;
                end
            end
            ST_WR_WAIT: begin
                port_wr_req = 1'b1;
                if (port_wr_ready) begin
                    exec_en   = 1'b1;
                    jmpCond   = seq_sel;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/tis_node_seq.md
TIS_NODE_SEQ -- requirements
Module: tis_node_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and reset as elsewhere in the codebase.
REQ-002 SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- run_en  in  1  node enable.
- instr  in  18 [0:17]  current instruction word; opcode is instr[0:4], absolute target is instr[10:17].
- ip  in  8 [0:7]  current instruction pointer from the jump datapath.
- prog_last  in  8 [0:7]  address of the last valid program line.
- acc  in  11 [0:10]  signed ACC, two's complement.
- port_rd_valid  in  1  source port has data.
- port_wr_ready  in  1  destination port accepted data.
- jmpCond  out  2 [0:1]  next-IP select: 00 = ip+1, 01 = jAddr, 10 = instr[10:17], 11 = zero.
- jmpInstr  out  1  current instruction is a jump class.
- jAddr  out  8 [0:7]  explicit next-IP value.
- exec_en  out  1  one-cycle retire strobe; the datapath commits ACC/BAK on it.
- port_rd_req  out  1  read handshake request.
- port_wr_req  out  1  write handshake request.
- err_illegal  out  1  one-cycle error pulse.

Function
REQ-003 SHALL decode these opcodes (instr[0:4]):
- 00 NOP; 01 SWP; 02 SAV; 03 NEG; 04 ADD; 05 SUB; 06 MOV internal.
- 08 MOV from port; 0A ADD from port; 0B SUB from port.
- 09 MOV to port.
- 10 JMP; 11 JEZ; 12 JNZ; 13 JGZ; 14 JLZ; 15 JRO.
- Any other code is illegal.
REQ-004 SHALL implement FSM states IDLE, RUN, RD_WAIT, WR_WAIT.
REQ-005 SHALL make these state transitions:
- IDLE -> RUN when run_en=1.
- RUN -> IDLE when run_en=0; this is evaluated before decode.
- RUN -> RD_WAIT on opcode 08/0A/0B.
- RUN -> WR_WAIT on opcode 09.
- RD_WAIT -> RUN when port_rd_valid=1.
- WR_WAIT -> RUN when port_wr_ready=1.
REQ-006 SHALL hold the IP (jmpCond=01, jAddr=ip) in IDLE, in RD_WAIT/WR_WAIT while not completing, and in RUN on the cycle a port opcode is decoded.
REQ-007 In RUN, non-port opcodes SHALL retire in the same cycle: exec_en=1 and the next IP is selected that cycle.
REQ-008 Port opcodes SHALL retire on the completing wait cycle (exec_en=1, IP advances), giving a minimum latency of 2 cycles.
REQ-009 port_rd_req SHALL be 1 exactly while in RD_WAIT, and port_wr_req exactly while in WR_WAIT; both are Moore outputs.
REQ-010 run_en SHALL be ignored in RD_WAIT/WR_WAIT; a started handshake always completes.
REQ-011 Sequential advance SHALL select jmpCond=00, except when ip==prog_last, which SHALL select 11 (wrap to 0).
REQ-012 JMP, and a taken JEZ/JNZ/JGZ/JLZ, SHALL select jmpCond=10.
- Conditions: JEZ acc==0; JNZ acc!=0; JGZ acc>0; JLZ acc<0.
- A target greater than prog_last SHALL instead select 11 and pulse err_illegal.
REQ-013 An untaken conditional jump SHALL use sequential advance (REQ-011).
REQ-014 JRO SHALL compute sum = ip + sign-extended acc at 12-bit signed width, clamp it to [0, prog_last], drive jAddr with the result and select jmpCond=01.
REQ-015 jmpInstr SHALL be 1 only in RUN with opcode 10-15.
REQ-016 An illegal opcode in RUN SHALL retire as a NOP (exec_en=1, sequential advance) and pulse err_illegal.
REQ-017 jAddr SHALL equal ip whenever it is not driving a JRO target.
REQ-018 When prog_last==0, every advance and every JRO SHALL resolve to address 0.

Reset
REQ-019 While reset=0, the FSM SHALL be forced to IDLE asynchronously, and the outputs SHALL be:
- jmpCond=01, jAddr=ip;
- jmpInstr=0, exec_en=0;
- port_rd_req=0, port_wr_req=0, err_illegal=0.
REQ-020 Reset asserted during RD_WAIT/WR_WAIT SHALL drop the request immediately and discard the pending instruction without issuing exec_en.
REQ-021 After reset is released, the block SHALL first reach RUN on the first rising edge with run_en=1.

Structure
REQ-022 Package tis100_pkg SHALL hold:
- the opcode constants;
- the jmpCond encodings (SEL_INC, SEL_JADDR, SEL_ABS, SEL_ZERO);
- the FSM state encoding;
- the ACC width constant (11).
REQ-023 The JRO add-and-clamp logic SHALL be a combinational sub-module named jro_clamp (inputs ip, acc, prog_last; output target).
REQ-024 All state SHALL be held in a single register bank clocked on posedge clk with negedge reset.

Verification
REQ-025 Straight line: prog_last=3, NOPs, run_en=1 -> IP sequence 0,1,2,3,0 with exec_en every cycle.
REQ-026 Port read: opcode 08 at ip=2, port_rd_valid raised 3 cycles after entering RD_WAIT -> IP held at 2 for 4 cycles, port_rd_req high for 3 wait cycles, a single exec_en, then IP=3.
REQ-027 Conditional jumps: JEZ to 5 with acc=0 -> jmpCond=10, next IP=5; the same instruction with acc=1 -> jmpCond=00; JLZ with acc=-1 -> taken.
REQ-028 JRO clamping with prog_last=9:
- ip=4, acc=-7 -> jAddr=0.
- ip=4, acc=20 -> jAddr=9.
- ip=4, acc=2 -> jAddr=6.
REQ-029 Reset mid-wait: opcode 09 in WR_WAIT with port_wr_ready=0, reset pulled low -> port_wr_req=0 within the same cycle, no exec_en, state IDLE.
REQ-030 Error cases:
- opcode 1F -> err_illegal pulse and IP+1.
- JMP to 12 with prog_last=9 -> jmpCond=11 and err_illegal.
